// File: rtl/sensor_frame_pkg.sv
// Shared constants and types for the sensor telemetry frame transmitter.
// Holds the FSM state encoding, the UART bit count and the sensor register
// address range shared with the register file.
// Optional feature macro: SENSOR_FRAME_SEQ_EN (adds the sequence-byte state).
package sensor_frame_pkg;

  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned UART_BITS         = 10;   // start + 8 data + stop
  localparam int unsigned SENSOR_FIRST_ADDR = 1;
  localparam int unsigned SENSOR_LAST_ADDR  = 23;
  localparam logic [BYTE_W-1:0] DEF_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
`ifdef SENSOR_FRAME_SEQ_EN
    ST_SEQ,
`endif
    ST_PAYLOAD,
    ST_CHKSUM,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sensor_frame_tx_if.sv
// Frame transmitter bus: start request, register-file address/data pair,
// UART line and frame status.
//   master : frame requester / register file side (drives start, data)
//   slave  : sensor_frame_tx (drives addr, tx, busy, frame_done)
interface sensor_frame_tx_if;
  import sensor_frame_pkg::*;

  logic              start;
  logic [BYTE_W-1:0] data;
  logic [BYTE_W-1:0] addr;
  logic              tx;
  logic              busy;
  logic              frame_done;

  modport master (output start, data, input addr, tx, busy, frame_done);
  modport slave  (input start, data, output addr, tx, busy, frame_done);

endinterface

// File: rtl/uart_tx_byte.sv
// UART byte serialiser: 1 start bit, 8 data bits LSB first, 1 stop bit,
// each bit CLK_DIV cycles long.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   load      : request to send din (taken only while ready_c=1)
//   din       : byte to send
//   ready_c   : high when idle or in the final cycle of the stop bit
//   tx        : serial line, idle high
module uart_tx_byte
  import sensor_frame_pkg::*;
#(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BYTE_W-1:0] din,
  output logic              ready_c,
  output logic              tx
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(UART_BITS);

  logic               active_q;
  logic [DIV_W-1:0]   div_q;
  logic [BIT_W-1:0]   bit_q;
  logic [UART_BITS-2:0] shreg_q;   // remaining bits: {stop, data}
  logic               bit_end_c;
  logic               last_bit_c;

  assign bit_end_c  = (div_q == DIV_W'(CLK_DIV - 1));
  assign last_bit_c = (bit_q == BIT_W'(UART_BITS - 1));
  // Ready in the last stop-bit cycle lets the next byte follow with no gap.
  assign ready_c    = !active_q || (bit_end_c && last_bit_c);

  // Bit timing and shifting; a load always starts with the start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '1;
      tx       <= 1'b1;
    end else if (load && ready_c) begin
      active_q <= 1'b1;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= {1'b1, din};
      tx       <= 1'b0;
    end else if (active_q) begin
      if (bit_end_c) begin
        div_q <= '0;
        if (last_bit_c) begin
          active_q <= 1'b0;
        end else begin
          tx      <= shreg_q[0];
          shreg_q <= {1'b1, shreg_q[UART_BITS-2:1]};
          bit_q   <= bit_q + BIT_W'(1);
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/sensor_frame_tx.sv
// Sensor telemetry frame transmitter. Sweeps the register-file address range
// FIRST_ADDR..LAST_ADDR, and sends SYNC_BYTE, [sequence byte], the payload
// bytes and a two's-complement checksum back-to-back over a UART line.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   bus      : sensor_frame_tx_if.slave (start, data in; addr, tx, busy,
//              frame_done out)
// Optional feature macro: SENSOR_FRAME_SEQ_EN inserts a wrapping 8-bit frame
// sequence byte after SYNC, included in the checksum.
module sensor_frame_tx
  import sensor_frame_pkg::*;
#(
  parameter int unsigned       CLK_DIV    = 434,
  parameter int unsigned       FIRST_ADDR = SENSOR_FIRST_ADDR,
  parameter int unsigned       LAST_ADDR  = SENSOR_LAST_ADDR,
  parameter logic [BYTE_W-1:0] SYNC_BYTE  = DEF_SYNC_BYTE
) (
  input  logic               clk,
  input  logic               rst,
  sensor_frame_tx_if.slave   bus
);

  localparam logic [BYTE_W-1:0] FIRST_A = BYTE_W'(FIRST_ADDR);
  localparam logic [BYTE_W-1:0] LAST_A  = BYTE_W'(LAST_ADDR);

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] addr_q, addr_d;
  logic [BYTE_W-1:0] sum_q, sum_d;
  logic              last_q, last_d;    // final payload byte already loaded
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef SENSOR_FRAME_SEQ_EN
  logic [BYTE_W-1:0] seq_q, seq_d;
`endif

  logic              load_c;
  logic [BYTE_W-1:0] byte_c;
  logic              fetch_c;
  logic              tx_ready_c;

  uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_uart (
    .clk     (clk),
    .rst     (rst),
    .load    (load_c),
    .din     (byte_c),
    .ready_c (tx_ready_c),
    .tx      (bus.tx)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      sum_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SENSOR_FRAME_SEQ_EN
      seq_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SENSOR_FRAME_SEQ_EN
      seq_q   <= seq_d;
`endif
    end
  end

  // Next state; every byte is loaded in the UART's ready cycle so bytes
  // run back-to-back, and data is sampled in that same cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load_c  = 1'b0;
    byte_c  = SYNC_BYTE;
    fetch_c = 1'b0;
`ifdef SENSOR_FRAME_SEQ_EN
    seq_d   = seq_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load_c  = 1'b1;
          byte_c  = SYNC_BYTE;
          busy_d  = 1'b1;
          sum_d   = '0;
          last_d  = 1'b0;
          state_d = ST_SYNC;
`ifdef SENSOR_FRAME_SEQ_EN
          addr_d  = '0;
`else
          addr_d  = FIRST_A;
`endif
        end
      end
      ST_SYNC: begin
        if (tx_ready_c) begin
`ifdef SENSOR_FRAME_SEQ_EN
          load_c  = 1'b1;
          byte_c  = seq_q;
          sum_d   = sum_q + seq_q;
          addr_d  = FIRST_A;
          state_d = ST_SEQ;
`else
          fetch_c = 1'b1;
`endif
        end
      end
`ifdef SENSOR_FRAME_SEQ_EN
      ST_SEQ: begin
        if (tx_ready_c) fetch_c = 1'b1;
      end
`endif
      ST_PAYLOAD: begin
        if (tx_ready_c) begin
          if (last_q) begin
            load_c  = 1'b1;
            byte_c  = ~sum_q + BYTE_W'(1);
            state_d = ST_CHKSUM;
          end else begin
            fetch_c = 1'b1;
          end
        end
      end
      ST_CHKSUM: begin
        if (tx_ready_c) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef SENSOR_FRAME_SEQ_EN
        seq_d   = seq_q + BYTE_W'(1);
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Sample the current address's data and move addr to the next one.
    if (fetch_c) begin
      load_c  = 1'b1;
      byte_c  = bus.data;
      sum_d   = sum_q + bus.data;
      state_d = ST_PAYLOAD;
      if (addr_q == LAST_A) begin
        addr_d = '0;
        last_d = 1'b1;
      end else begin
        addr_d = addr_q + BYTE_W'(1);
      end
    end
  end

  assign bus.addr       = addr_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_sensor_frame_tx.sv
// Self-checking bench for sensor_frame_tx: register-file model with
// selectable contents, frame reference built from the byte list, and
// cycle-exact checking of the serial line, address bus and status outputs.
module tb_sensor_frame_tx;
  import sensor_frame_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int FIRST   = int'(SENSOR_FIRST_ADDR);
  localparam int LAST    = int'(SENSOR_LAST_ADDR);
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef SENSOR_FRAME_SEQ_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 1;
`endif
  localparam int NBYTES = HDR + (LAST - FIRST + 1) + 1;
  localparam int BITS   = int'(UART_BITS);

  logic clk = 1'b0;
  logic rst;
  sensor_frame_tx_if bus ();

  sensor_frame_tx #(
    .CLK_DIV   (CLK_DIV),
    .FIRST_ADDR(FIRST),
    .LAST_ADDR (LAST),
    .SYNC_BYTE (SYNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Register file model; optional one-cycle corruption right after addr moves.
  logic [7:0] mem [256];
  logic       glitch_en;
  logic [7:0] addr_prev;
  always @(posedge clk) addr_prev <= bus.addr;
  always_comb bus.data = mem[bus.addr] ^ ((glitch_en && (bus.addr != addr_prev)) ? 8'h5A : 8'h00);

  int n_cmp  = 0;
  int n_fail = 0;
  int seq_m  = 0;

  logic [7:0] exp_b [NBYTES];
  logic [7:0] exp_a [NBYTES];
  int         pa    [NBYTES+1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected frame: header, payload in address order, negated byte sum.
  // addr during a byte is the address of the following byte if it is payload.
  task automatic build_model();
    int k;
    int sum;
    k   = 0;
    sum = 0;
    exp_b[k] = SYNC; pa[k] = -1; k++;
`ifdef SENSOR_FRAME_SEQ_EN
    exp_b[k] = 8'(seq_m); pa[k] = -1; sum += seq_m; k++;
`endif
    for (int a = FIRST; a <= LAST; a++) begin
      exp_b[k] = mem[a]; pa[k] = a; sum += int'(mem[a]); k++;
    end
    exp_b[k] = 8'((256 - (sum % 256)) % 256); pa[k] = -1;
    pa[NBYTES] = -1;
    for (int i = 0; i < NBYTES; i++)
      exp_a[i] = (pa[i+1] >= 0) ? 8'(pa[i+1]) : 8'h00;
  endtask

  // Called at a negedge; start is seen by the following rising edge.
  task automatic start_frame();
    build_model();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Entered at the negedge of the first cycle after start acceptance.
  task automatic check_frame(input int pulse_byte, input bit pulse_done);
    logic [9:0] obs;
    logic [7:0] bad_addr;
    bit         unstable, addr_bad, stat_bad;
    for (int i = 0; i < NBYTES; i++) begin
      obs = '0; unstable = 0; addr_bad = 0; stat_bad = 0; bad_addr = 8'h00;
      for (int b = 0; b < BITS; b++) begin
        for (int c = 0; c < CLK_DIV; c++) begin
          if (c == 0) obs[b] = bus.tx;
          else if (bus.tx !== obs[b]) unstable = 1;
          if (bus.addr !== exp_a[i]) begin addr_bad = 1; bad_addr = bus.addr; end
          if (bus.busy !== 1'b1 || bus.frame_done !== 1'b0) stat_bad = 1;
          bus.start = (i == pulse_byte && b == 0 && c == 0);
          @(negedge clk);
        end
      end
      chk($sformatf("byte%0d_line", i), 32'({unstable, obs}), 32'({1'b0, 1'b1, exp_b[i], 1'b0}));
      chk($sformatf("byte%0d_addr", i), 32'(addr_bad ? bad_addr : exp_a[i]), 32'(exp_a[i]));
      chk($sformatf("byte%0d_busy", i), 32'(stat_bad), 32'(0));
    end
    chk("done_cycle", 32'({bus.frame_done, bus.busy, bus.tx, bus.addr}), 32'({3'b101, 8'h00}));
    bus.start = pulse_done;
    @(negedge clk);
    bus.start = 1'b0;
    chk("after_done", 32'({bus.frame_done, bus.busy, bus.tx, bus.addr}), 32'({3'b001, 8'h00}));
    seq_m = (seq_m + 1) % 256;
  endtask

  task automatic quiet_check(input int cycles);
    bit bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) bad = 1;
      @(negedge clk);
    end
    chk("idle_quiet", 32'(bad), 32'(0));
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    glitch_en = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    // Power-on reset.
    #1 rst = 1'b0;
    #1 chk("por", 32'({bus.tx, bus.busy, bus.frame_done, bus.addr}), 32'({3'b100, 8'h00}));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // data = addr, late-sample corruption on, start mid-payload and on DONE.
    glitch_en = 1'b1;
    start_frame();
    check_frame(10, 1'b1);

    // Back-to-back frame from the cycle after frame_done: all 0xFF payload.
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    start_frame();
    check_frame(-1, 1'b0);

    // Random payload after an idle gap.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (5) @(negedge clk);
    start_frame();
    check_frame(3, 1'b0);

    // Reset while idle.
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("rst_idle", 32'({bus.tx, bus.busy, bus.frame_done, bus.addr}), 32'({3'b100, 8'h00}));
    @(negedge clk);
    rst = 1'b1;
    seq_m = 0;
    @(negedge clk);

    // Reset mid-payload, in a start bit so tx is low when it hits.
    start_frame();
    repeat (10 * CLK_DIV * 5 + 1) @(negedge clk);
    chk("pre_rst_tx", 32'({bus.tx, bus.busy}), 32'({1'b0, 1'b1}));
    #2 rst = 1'b0;
    #1 chk("rst_frame", 32'({bus.tx, bus.busy, bus.frame_done, bus.addr}), 32'({3'b100, 8'h00}));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    seq_m = 0;
    quiet_check(300);

    // Fresh frame after the abort, random data.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    start_frame();
    check_frame(-1, 1'b0);

`ifdef SENSOR_FRAME_SEQ_EN
    // A few more frames to advance the sequence byte with data = addr.
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    for (int f = 0; f < 2; f++) begin
      start_frame();
      check_frame(-1, 1'b0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
